line_cache: RTL and testbench
=============================

// Module: line_cache
// PURPOSE
//  Direct-mapped, write-back, write-allocate cache. It is the responder for the CPU datapath's
//  line-wide memory interface: 16-bit byte address, 128-bit line data, word placed by addr[3:1].
//  It sits between the CPU and physical memory and issues line reads/writes to the memory on misses.
// PARAMETERS
//  IDX_BITS   3   set-index width; number of sets = 2**IDX_BITS; tag = 12-IDX_BITS bits
// PORTS
//  clk              in   1    system clock; all state changes on rising edge
//  rst              in   1    synchronous reset, active-high
//  mem_read         in   1    CPU read request; held by CPU until mem_resp
//  mem_write        in   1    CPU write request; held by CPU until mem_resp
//  mem_byte_enable  in   16   per-byte write mask of the 128-bit line
//  mem_address      in   16   CPU byte address (offset [3:0], index, tag)
//  mem_wdata        in   128  CPU write data, already shifted to its word position
//  mem_rdata        out  128  full cached line; valid while mem_resp=1
//  mem_resp         out  1    one-cycle completion pulse to CPU
//  pmem_read        out  1    line read request to memory; held until pmem_resp
//  pmem_write       out  1    line write request to memory; held until pmem_resp
//  pmem_address     out  16   line-aligned address, [3:0]=0
//  pmem_wdata       out  128  victim line for writeback
//  pmem_rdata       in   128  fill line from memory
//  pmem_resp        in   1    memory completion, one cycle
// BEHAVIOUR
//  - Reset: state=IDLE; all valid and dirty bits=0; mem_resp, pmem_read, pmem_write=0; pmem_address=0.
//    Data and tag arrays are not reset.
//  - FSM states: IDLE, COMPARE, WRITEBACK, FILL.
//  - IDLE: if mem_read|mem_write -> COMPARE; otherwise stay.
//  - COMPARE: hit = valid[idx] && tag[idx]==addr tag.
//    * Hit: mem_resp=1 this cycle, combinational; next state IDLE.
//      Read: mem_rdata=line[idx].
//      Write: bytes with mem_byte_enable=1 take mem_wdata at the edge.
//      dirty[idx] is set only if mem_byte_enable != 0.
//    * Miss, dirty victim -> WRITEBACK. Miss, clean or invalid victim -> FILL.
//    * Neither request asserted -> IDLE with no response.
//  - WRITEBACK: pmem_write=1, pmem_address={victim tag,idx,4'h0}, pmem_wdata=line[idx].
//    On pmem_resp: dirty[idx]=0 -> FILL.
//  - FILL: pmem_read=1, pmem_address={addr[15:4],4'h0}.
//    On pmem_resp: line[idx]=pmem_rdata, tag updated, valid=1, dirty=0 -> COMPARE, which then hits.
//  - Latency:
//    * Hit: mem_resp 1 cycle after the request is first seen in IDLE.
//    * Clean miss: fill time + 2 cycles.
//    * Dirty miss: adds writeback time.
//  - pmem strobes are decoded from state. They drop on the cycle after pmem_resp.
//    Never assert pmem_read and pmem_write together.
//  - mem_read and mem_write both high: treat as a write.
//  - A miss, once started, completes its writeback/fill even if the CPU drops the request.
//  - rst mid-WRITEBACK or mid-FILL abandons the transfer; strobes are 0 on the next cycle.
//  - pmem_resp outside WRITEBACK/FILL is ignored.
//  - mem_rdata outside mem_resp is don't-care but must not be X after the first fill.
// STRUCTURE
//  - lc3b_types package additions:
//    lc3b_c_tag [12-IDX_BITS-1:0], lc3b_c_index, lc3b_mem_wmask [15:0], cache_state_t enum.
//  - Sub-module cache_line_array: holds data/tag/valid/dirty arrays.
//    Single index port; byte-masked line write; tag/valid/dirty load strobes; synchronous rst clears valid/dirty.
//  - FSM and hit compare live in line_cache.
// TESTING
//  1. Cold read 0x0046 -> pmem_read, pmem_address=0x0040; memory returns line L after 3 cycles
//     -> mem_resp with mem_rdata=L; no pmem_write.
//  2. Repeat read 0x0046 -> mem_resp exactly 1 cycle after IDLE sees request; pmem_read stays 0.
//  3. Write 0x0044, byte_enable=16'h0030, wdata=128'hBEEF<<32 -> hit; line word2=0xBEEF; dirty=1.
//     Then read 0x0446 (same index, new tag) -> pmem_write at 0x0040 carrying merged line, then pmem_read at 0x0440.
//  4. Write with byte_enable=0 to a clean hit line, then evict
//     -> no writeback; only pmem_read issued.
//  5. Assert rst during FILL -> next cycle pmem_read=0, mem_resp=0, state IDLE.
//     Prior hit line now misses (valid cleared).
//  6. pmem_resp with 0 extra wait vs 10 wait cycles, and a stray pmem_resp in IDLE
//     -> identical data results; stray pulse causes no state change.

Source files
------------

// File: rtl/line_cache_pkg.sv
// Shared types for the direct-mapped line cache: address field widths,
// byte mask and the controller state encoding.
package line_cache_pkg;

  localparam int DEF_IDX_BITS = 3;
  localparam int DEF_TAG_BITS = 12 - DEF_IDX_BITS;

  typedef logic [DEF_TAG_BITS-1:0] lc3b_c_tag;
  typedef logic [DEF_IDX_BITS-1:0] lc3b_c_index;
  typedef logic [15:0]             lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WRITEBACK,
    ST_FILL
  } cache_state_t;

  function automatic logic [15:0] line_base(input logic [15:0] addr);
    return {addr[15:4], 4'h0};
  endfunction

endpackage

// File: rtl/line_cache_array.sv
// Storage for the cache: per-set 128-bit line, tag, valid and dirty bits.
// Reads are combinational on the single index; valid/dirty clear on reset.
module cache_line_array
  import line_cache_pkg::*;
#(
  parameter int IDX_BITS = DEF_IDX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_BITS-1:0]   index,
  input  lc3b_mem_wmask         data_we,
  input  logic [127:0]          data_in,
  input  logic                  tag_load,
  input  logic [11-IDX_BITS:0]  tag_in,
  input  logic                  valid_load,
  input  logic                  valid_in,
  input  logic                  dirty_load,
  input  logic                  dirty_in,
  output logic [127:0]          data_out,
  output logic [11-IDX_BITS:0]  tag_out,
  output logic                  valid_out,
  output logic                  dirty_out
);

  localparam int SETS = 1 << IDX_BITS;

  logic [127:0]         data_q [SETS];
  logic [11-IDX_BITS:0] tag_q  [SETS];
  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;

  // Data and tags are deliberately left out of reset; valid gates their use.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 16; b++) begin
      if (data_we[b]) data_q[index][8*b +: 8] <= data_in[8*b +: 8];
    end
    if (tag_load) tag_q[index] <= tag_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (valid_load) valid_q[index] <= valid_in;
      if (dirty_load) dirty_q[index] <= dirty_in;
    end
  end

  assign data_out  = data_q[index];
  assign tag_out   = tag_q[index];
  assign valid_out = valid_q[index];
  assign dirty_out = dirty_q[index];

endmodule

// File: rtl/line_cache.sv
// Direct-mapped write-back, write-allocate cache controller between the CPU
// line interface and physical memory.
module line_cache
  import line_cache_pkg::*;
#(
  parameter int IDX_BITS = DEF_IDX_BITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [15:0]   mem_byte_enable,
  input  logic [15:0]   mem_address,
  input  logic [127:0]  mem_wdata,
  output logic [127:0]  mem_rdata,
  output logic          mem_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp,
  output cache_state_t  dbg_state
);

  localparam int TAG_BITS = 12 - IDX_BITS;

  // Handshake: CPU holds mem_read/mem_write (and address/data) until the
  // single-cycle mem_resp; the cache holds pmem_read/pmem_write until the
  // single-cycle pmem_resp and drops the strobe on the following cycle.
  cache_state_t          state;
  logic [15:4]           line_q;
  logic [IDX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  req;
  logic                  hit;

  lc3b_mem_wmask         data_we;
  logic [127:0]          data_in;
  logic                  tag_load;
  logic                  valid_load;
  logic                  dirty_load;
  logic                  dirty_in;
  logic [127:0]          line_data;
  logic [TAG_BITS-1:0]   line_tag;
  logic                  line_valid;
  logic                  line_dirty;
  logic                  unused_offset;

  // The line address is captured when IDLE accepts a request so an
  // in-flight miss finishes even if the CPU withdraws.
  assign idx           = line_q[4 +: IDX_BITS];
  assign tag           = line_q[15 -: TAG_BITS];
  assign req           = mem_read | mem_write;
  assign hit           = line_valid && (line_tag == tag);
  assign unused_offset = ^mem_address[3:0];

  cache_line_array #(.IDX_BITS(IDX_BITS)) u_array (
    .clk        (clk),
    .rst        (rst),
    .index      (idx),
    .data_we    (data_we),
    .data_in    (data_in),
    .tag_load   (tag_load),
    .tag_in     (tag),
    .valid_load (valid_load),
    .valid_in   (1'b1),
    .dirty_load (dirty_load),
    .dirty_in   (dirty_in),
    .data_out   (line_data),
    .tag_out    (line_tag),
    .valid_out  (line_valid),
    .dirty_out  (line_dirty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      line_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            state  <= ST_COMPARE;
            line_q <= mem_address[15:4];
          end
        end
        ST_COMPARE: begin
          if (!req || hit)                 state <= ST_IDLE;
          else if (line_valid && line_dirty) state <= ST_WRITEBACK;
          else                             state <= ST_FILL;
        end
        ST_WRITEBACK: if (pmem_resp) state <= ST_FILL;
        ST_FILL:      if (pmem_resp) state <= ST_COMPARE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

  // Array update strobes; a write with an empty mask still completes but
  // leaves the line clean.
  always_comb begin
    data_we    = '0;
    data_in    = pmem_rdata;
    tag_load   = 1'b0;
    valid_load = 1'b0;
    dirty_load = 1'b0;
    dirty_in   = 1'b0;
    mem_resp   = 1'b0;
    unique case (state)
      ST_COMPARE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          if (mem_write) begin
            data_we = mem_byte_enable;
            data_in = mem_wdata;
            if (|mem_byte_enable) begin
              dirty_load = 1'b1;
              dirty_in   = 1'b1;
            end
          end
        end
      end
      ST_WRITEBACK: dirty_load = pmem_resp;
      ST_FILL: begin
        if (pmem_resp) begin
          data_we    = '1;
          tag_load   = 1'b1;
          valid_load = 1'b1;
          dirty_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    pmem_address = 16'h0000;
    unique case (state)
      ST_WRITEBACK: pmem_address = {line_tag, idx, 4'h0};
      ST_FILL:      pmem_address = line_base({line_q, 4'h0});
      default:      pmem_address = 16'h0000;
    endcase
  end

  assign pmem_read  = (state == ST_FILL);
  assign pmem_write = (state == ST_WRITEBACK);
  assign pmem_wdata = line_data;
  assign mem_rdata  = line_valid ? line_data : '0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_line_cache.sv
// Bench for line_cache: directed vector table, multi-cycle corner sequences
// and random traffic checked against a flat-memory reference model.
module tb_line_cache;
  import line_cache_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_byte_enable;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  cache_state_t dbg_state;

  always #5 clk = ~clk;

  line_cache #(.IDX_BITS(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .dbg_state       (dbg_state)
  );

  // Physical memory seen by the cache, and the CPU-visible memory image.
  logic [127:0] mem_model [4096];
  logic [127:0] golden    [4096];
  logic         rv [8];
  logic [8:0]   rt [8];
  logic         rd [8];

  // Memory transactions: {is_write, address, data (0 for reads)}.
  logic [144:0] exp_q[$];
  logic [144:0] act_q[$];

  int checks = 0;
  int errors = 0;
  int mem_lat;
  int mem_wait;

  typedef struct {
    logic         wr;
    logic         rd_too;
    logic [15:0]  addr;
    logic [15:0]  be;
    logic [127:0] wd;
    int           lat;
    int           exp_cycles;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // One negedge of the memory responder: wait mem_lat cycles, then pulse pmem_resp.
  task automatic mem_step();
    check("pmem_exclusive", 160'(pmem_read && pmem_write), 160'(0));
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      mem_wait  = 0;
    end else if (pmem_read || pmem_write) begin
      if (mem_wait == mem_lat) begin
        pmem_resp = 1'b1;
        if (pmem_write) begin
          mem_model[pmem_address[15:4]] = pmem_wdata;
          act_q.push_back({1'b1, pmem_address, pmem_wdata});
        end else begin
          pmem_rdata = mem_model[pmem_address[15:4]];
          act_q.push_back({1'b0, pmem_address, 128'h0});
        end
      end else begin
        mem_wait++;
      end
    end
  endtask

  // Reference: a miss writes back a dirty victim, then fills; latency follows
  // the responder timing (hit 1, clean 3+lat, dirty 5+2*lat).
  task automatic model_access(input logic wr, input logic [15:0] addr, input logic [15:0] be,
                              input logic [127:0] wd, input int lat,
                              output int exp_cycles, output logic [127:0] exp_rdata);
    logic [2:0]  idx;
    logic [8:0]  tag;
    logic [11:0] line;
    idx  = addr[6:4];
    tag  = addr[15:7];
    line = addr[15:4];
    exp_q.delete();
    if (rv[idx] && rt[idx] == tag) begin
      exp_cycles = 1;
    end else begin
      if (rv[idx] && rd[idx]) begin
        exp_q.push_back({1'b1, rt[idx], idx, 4'h0, golden[{rt[idx], idx}]});
        exp_cycles = 5 + 2 * lat;
      end else begin
        exp_cycles = 3 + lat;
      end
      exp_q.push_back({1'b0, line, 4'h0, 128'h0});
      rv[idx] = 1'b1;
      rt[idx] = tag;
      rd[idx] = 1'b0;
    end
    exp_rdata = golden[line];
    if (wr) begin
      for (int b = 0; b < 16; b++) begin
        if (be[b]) golden[line][8*b +: 8] = wd[8*b +: 8];
      end
      if (be != 16'h0) rd[idx] = 1'b1;
    end
  endtask

  // Reset discards dirty lines: the CPU view falls back to physical memory.
  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      if (rv[s] && rd[s]) golden[{rt[s], 3'(s)}] = mem_model[{rt[s], 3'(s)}];
      rv[s] = 1'b0;
      rd[s] = 1'b0;
    end
  endtask

  task automatic do_access(input logic wr, input logic rd_too, input logic [15:0] addr,
                           input logic [15:0] be, input logic [127:0] wd, input int lat,
                           output logic [127:0] rdata, output int cycles, output logic got);
    @(negedge clk);
    mem_read        = !wr || rd_too;
    mem_write       = wr;
    mem_address     = addr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    mem_lat         = lat;
    mem_wait        = 0;
    act_q.delete();
    cycles = 0;
    got    = 1'b0;
    rdata  = '0;
    while (!got && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (mem_resp) begin
        got   = 1'b1;
        rdata = mem_rdata;
      end
      mem_step();
    end
    @(negedge clk);
    check("resp_single_cycle", 160'(mem_resp), 160'(0));
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic check_log(input string name);
    check({name, " pmem_count"}, 160'(act_q.size()), 160'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check({name, " pmem_txn"}, 160'(act_q[i]), 160'(exp_q[i]));
  endtask

  task automatic run_access(input string name, input logic wr, input logic rd_too,
                            input logic [15:0] addr, input logic [15:0] be,
                            input logic [127:0] wd, input int lat, input int tbl_cycles);
    int           mc;
    int           ac;
    logic [127:0] mr;
    logic [127:0] ar;
    logic         got;
    model_access(wr, addr, be, wd, lat, mc, mr);
    do_access(wr, rd_too, addr, be, wd, lat, ar, ac, got);
    check({name, " resp_seen"}, 160'(got), 160'(1));
    check({name, " latency"}, 160'(ac), 160'((tbl_cycles >= 0) ? tbl_cycles : mc));
    if (!wr) check({name, " rdata"}, 160'(ar), 160'(mr));
    check_log(name);
  endtask

  initial begin
    int           n;
    logic         seen;
    logic         dropped;
    int           mc;
    logic [127:0] mr;

    for (int i = 0; i < 4096; i++) begin
      mem_model[i] = {8{4'h5, 12'(i)}};
      golden[i]    = mem_model[i];
    end
    for (int s = 0; s < 8; s++) begin
      rv[s] = 1'b0;
      rd[s] = 1'b0;
      rt[s] = '0;
    end

    vecs[0]  = '{1'b0, 1'b0, 16'h0046, 16'h0000, 128'h0,                 3,  6};
    vecs[1]  = '{1'b0, 1'b0, 16'h0046, 16'h0000, 128'h0,                 0,  1};
    vecs[2]  = '{1'b1, 1'b0, 16'h0044, 16'h0030, 128'hBEEF << 32,        0,  1};
    vecs[3]  = '{1'b0, 1'b0, 16'h0446, 16'h0000, 128'h0,                 2,  9};
    vecs[4]  = '{1'b0, 1'b0, 16'h0046, 16'h0000, 128'h0,                 0,  3};
    vecs[5]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 128'hDEAD_0000_FFFF,    0,  1};
    vecs[6]  = '{1'b0, 1'b0, 16'h0440, 16'h0000, 128'h0,                 1,  4};
    vecs[7]  = '{1'b0, 1'b0, 16'h1230, 16'h0000, 128'h0,                 0,  3};
    vecs[8]  = '{1'b0, 1'b0, 16'h1230, 16'h0000, 128'h0,                 5,  1};
    vecs[9]  = '{1'b0, 1'b0, 16'h2230, 16'h0000, 128'h0,                10, 13};
    vecs[10] = '{1'b1, 1'b1, 16'h2232, 16'h000C, 128'h1234 << 16,        0,  1};
    vecs[11] = '{1'b0, 1'b0, 16'h2232, 16'h0000, 128'h0,                 0,  1};

    rst             = 1'b1;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    mem_address     = '0;
    mem_wdata       = '0;
    pmem_rdata      = '0;
    pmem_resp       = 1'b0;
    mem_lat         = 0;
    mem_wait        = 0;
    repeat (3) @(negedge clk);
    check("reset mem_resp",     160'(mem_resp),     160'(0));
    check("reset pmem_read",    160'(pmem_read),    160'(0));
    check("reset pmem_write",   160'(pmem_write),   160'(0));
    check("reset pmem_address", 160'(pmem_address), 160'(0));
    check("reset state",        160'(dbg_state),    160'(ST_IDLE));
    rst = 1'b0;

    for (int v = 0; v < 12; v++)
      run_access($sformatf("vec%0d", v), vecs[v].wr, vecs[v].rd_too, vecs[v].addr,
                 vecs[v].be, vecs[v].wd, vecs[v].lat, vecs[v].exp_cycles);

    // Stray pmem_resp while idle must be ignored.
    @(negedge clk);
    pmem_rdata = {4{32'hA5A5_5A5A}};
    pmem_resp  = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("stray state",     160'(dbg_state),               160'(ST_IDLE));
    check("stray strobes",   160'({pmem_read, pmem_write}), 160'(0));
    check("stray mem_resp",  160'(mem_resp),                160'(0));
    run_access("after_stray", 1'b0, 1'b0, 16'h2232, 16'h0, 128'h0, 0, 1);

    // Reset in the middle of a fill abandons it and invalidates the cache.
    @(negedge clk);
    mem_read    = 1'b1;
    mem_address = 16'h5550;
    seen        = 1'b0;
    n           = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (pmem_read) seen = 1'b1;
    end
    check("rstfill pmem_read_seen", 160'(seen), 160'(1));
    rst      = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rstfill pmem_read", 160'(pmem_read),    160'(0));
    check("rstfill mem_resp",  160'(mem_resp),     160'(0));
    check("rstfill state",     160'(dbg_state),    160'(ST_IDLE));
    check("rstfill address",   160'(pmem_address), 160'(0));
    model_reset();
    run_access("after_rst", 1'b0, 1'b0, 16'h2232, 16'h0, 128'h0, 0, 3);

    // CPU withdraws its read during the fill: fill still completes, no response.
    model_access(1'b0, 16'h6660, 16'h0, 128'h0, 4, mc, mr);
    @(negedge clk);
    mem_read    = 1'b1;
    mem_address = 16'h6660;
    mem_lat     = 4;
    mem_wait    = 0;
    act_q.delete();
    seen    = 1'b0;
    dropped = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_resp) seen = 1'b1;
      if (pmem_read && !dropped) begin
        mem_read = 1'b0;
        dropped  = 1'b1;
      end
      mem_step();
    end
    check("drop started_fill", 160'(dropped),   160'(1));
    check("drop no_resp",      160'(seen),      160'(0));
    check("drop state",        160'(dbg_state), 160'(ST_IDLE));
    check_log("drop");
    run_access("drop_then_hit", 1'b0, 1'b0, 16'h6660, 16'h0, 128'h0, 0, 1);

    // Random traffic over a few conflicting tags per set.
    for (int r = 0; r < 150; r++) begin
      logic [15:0]  a;
      logic [15:0]  be;
      logic         wr;
      a  = {9'($urandom_range(0, 3) * 37), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0};
      wr = 1'($urandom_range(0, 1));
      be = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      run_access($sformatf("rand%0d", r), wr, 1'($urandom_range(0, 1)) & wr, a, be,
                 {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
